// File: rtl/projective_lift_if.sv
// Request/response bundle for projective_lift: affine point in, Montgomery-domain
// projective point out, with busy/finished status.
interface projective_lift_if #(
  parameter int unsigned W = 255
);
  logic         i_start;
  logic [W-1:0] i_x;
  logic [W-1:0] i_y;
  logic [W-1:0] o_x;
  logic [W-1:0] o_y;
  logic [W-1:0] o_z;
  logic         o_busy;
  logic         o_finished;

  modport slave (
    input  i_start, i_x, i_y,
    output o_x, o_y, o_z, o_busy, o_finished
  );

  modport master (
    output i_start, i_x, i_y,
    input  o_x, o_y, o_z, o_busy, o_finished
  );
endinterface

// File: rtl/projective_lift.sv
// Lifts an affine point (x, y) to projective Montgomery form (xR, yR, R) mod q using
// one shared bit-serial Montgomery multiplier.
module mont_mul #(
  parameter logic [254:0] P_Q = {{247{1'b1}}, 8'hed}
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [254:0] i_a,
  input  logic [254:0] i_b,
  output logic [254:0] o_montgomery,
  output logic         o_finished
);
  typedef enum logic [1:0] {MmIdle, MmRun, MmFix} mm_state_e;
  localparam logic [256:0] QExt = {2'b00, P_Q};

  mm_state_e    state_q, state_d;
  logic [254:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [256:0] t_q, t_d, acc, acc_odd;
  logic [7:0]   cnt_q, cnt_d;
  logic         fin_q, fin_d;

  // Radix-2 step: t stays below 2q, so 257 bits never overflow.
  always_comb begin
    acc     = t_q + (a_q[0] ? {2'b00, b_q} : 257'd0);
    acc_odd = acc + (acc[0] ? QExt : 257'd0);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    fin_d   = 1'b0;
    unique case (state_q)
      MmIdle: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          t_d     = '0;
          cnt_d   = '0;
          state_d = MmRun;
        end
      end
      MmRun: begin
        t_d   = acc_odd >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd254) state_d = MmFix;
      end
      default: begin
        res_d   = (t_q >= QExt) ? (t_q[254:0] - P_Q) : t_q[254:0];
        fin_d   = 1'b1;
        state_d = MmIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= MmIdle;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      fin_q   <= fin_d;
    end
  end

  assign o_montgomery = res_q;
  assign o_finished   = fin_q;
endmodule

module projective_lift #(
  parameter logic [254:0] P_Q      = {{247{1'b1}}, 8'hed},
  parameter logic [254:0] P_R_MOD  = 255'd19,
  parameter logic [254:0] P_R2_MOD = 255'd361
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  projective_lift_if.slave   lift_io
);
  typedef enum logic [1:0] {S_IDLE, S_MUL_X, S_MUL_Y, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [254:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic         busy_q, busy_d, fin_q, fin_d;
  logic [254:0] red_x, red_y, mul_a, mul_res;
  logic         mul_start, mul_fin;

  // 256-bit compare so inputs up to 2^255-1 reduce without wrap.
  assign red_x = ({1'b0, lift_io.i_x} >= {1'b0, P_Q}) ? (lift_io.i_x - P_Q) : lift_io.i_x;
  assign red_y = ({1'b0, lift_io.i_y} >= {1'b0, P_Q}) ? (lift_io.i_y - P_Q) : lift_io.i_y;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    busy_d    = busy_q;
    fin_d     = 1'b0;
    mul_start = 1'b0;
    mul_a     = red_x;
    unique case (state_q)
      S_IDLE: begin
        if (lift_io.i_start) begin
          x_d       = red_x;
          y_d       = red_y;
          mul_start = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_MUL_X;
        end
      end
      S_MUL_X: begin
        if (mul_fin) begin
          x_d       = mul_res;
          mul_a     = y_q;
          mul_start = 1'b1;
          state_d   = S_MUL_Y;
        end
      end
      S_MUL_Y: begin
        if (mul_fin) begin
          y_d     = mul_res;
          state_d = S_DONE;
        end
      end
      default: begin
        z_d     = P_R_MOD;
        fin_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  mont_mul #(
    .P_Q (P_Q)
  ) u_mul (
    .i_clk        (i_clk),
    .i_rst        (~i_rst_n),
    .i_start      (mul_start & i_rst_n),
    .i_a          (mul_a),
    .i_b          (P_R2_MOD),
    .o_montgomery (mul_res),
    .o_finished   (mul_fin)
  );

  assign lift_io.o_x        = x_q;
  assign lift_io.o_y        = y_q;
  assign lift_io.o_z        = z_q;
  assign lift_io.o_busy     = busy_q;
  assign lift_io.o_finished = fin_q;
endmodule

// File: tb/tb_projective_lift.sv
// Directed bench for projective_lift: hand-computed Montgomery lifts, latency against
// the multiplier, ignored restarts, back-to-back start and mid-operation reset.
module tb_projective_lift;
  localparam logic [254:0] Q = {{247{1'b1}}, 8'hed};

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_fin;
  int   mstart;
  int   lmm;
  int   n_pass;
  int   n_total;

  projective_lift_if bus ();

  projective_lift dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .lift_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Finished-pulse counter and multiplier start-to-finished latency probe.
  always @(negedge clk) begin
    if (bus.o_finished) n_fin <= n_fin + 1;
    if (dut.u_mul.i_start) mstart <= cyc;
    if (dut.u_mul.o_finished) lmm <= cyc - mstart;
  end

  task automatic chk(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [254:0] from_mont(input logic [254:0] v);
    logic [255:0] t;
    t = {1'b0, v};
    for (int i = 0; i < 255; i++) begin
      if (t[0]) t = t + {1'b0, Q};
      t = t >> 1;
    end
    return t[254:0];
  endfunction

  task automatic launch(input logic [254:0] x, input logic [254:0] y);
    bus.i_start = 1'b1;
    bus.i_x     = x;
    bus.i_y     = y;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_fin(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.o_finished) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " done"}, 255'(ok), 255'd1);
  endtask

  task automatic lift(input string tag, input logic [254:0] x, input logic [254:0] y,
                      input logic [254:0] ex, input logic [254:0] ey);
    int c0;
    int f0;
    c0 = cyc;
    f0 = n_fin;
    launch(x, y);
    chk({tag, " busy"}, 255'(bus.o_busy), 255'd1);
    wait_fin(tag);
    chk({tag, " lat"}, 255'(cyc - c0), 255'(2 * lmm + 2));
    chk({tag, " x"}, bus.o_x, ex);
    chk({tag, " y"}, bus.o_y, ey);
    chk({tag, " z"}, bus.o_z, 255'd19);
    @(negedge clk);
    chk({tag, " pulse width"}, 255'(bus.o_finished), 255'd0);
    chk({tag, " pulses"}, 255'(n_fin - f0), 255'd1);
  endtask

  initial begin
    logic [254:0] ax;
    int f0;
    cyc         = 0;
    n_fin       = 0;
    mstart      = 0;
    lmm         = 0;
    n_pass      = 0;
    n_total     = 0;
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_x     = '0;
    bus.i_y     = '0;
    repeat (3) @(negedge clk);
    chk("reset x", bus.o_x, 255'd0);
    chk("reset y", bus.o_y, 255'd0);
    chk("reset z", bus.o_z, 255'd0);
    chk("reset busy", 255'(bus.o_busy), 255'd0);
    chk("reset fin", 255'(bus.o_finished), 255'd0);
    rst_n = 1'b1;
    @(negedge clk);

    lift("one", 255'd1, 255'd1, 255'd19, 255'd19);
    lift("two_three", 255'd2, 255'd3, 255'd38, 255'd57);
    lift("q_q1", Q, Q + 255'd1, 255'd0, 255'd19);
    lift("qm1_0", Q - 255'd1, 255'd0, Q - 255'd19, 255'd0);

    // Back to affine: z lifts 1, so x = X*R^-1; even form keeps an even x unchanged.
    chk("affine z", from_mont(bus.o_z), 255'd1);
    ax = from_mont(bus.o_x);
    if (ax[0]) ax = Q - ax;
    chk("affine x", ax, Q - 255'd1);
    chk("affine y", from_mont(bus.o_y), 255'd0);

    // Restart during S_MUL_X must be ignored.
    f0 = n_fin;
    launch(255'd4, 255'd6);
    repeat (10) @(negedge clk);
    launch(255'd9, 255'd9);
    wait_fin("ignore");
    chk("ignore x", bus.o_x, 255'd76);
    chk("ignore y", bus.o_y, 255'd114);
    repeat (3) @(negedge clk);
    chk("ignore pulses", 255'(n_fin - f0), 255'd1);

    // New request on the o_finished cycle is accepted.
    launch(255'd1, 255'd2);
    wait_fin("b2b first");
    chk("b2b first x", bus.o_x, 255'd19);
    chk("b2b first y", bus.o_y, 255'd38);
    launch(255'd3, 255'd3);
    chk("b2b accepted busy", 255'(bus.o_busy), 255'd1);
    wait_fin("b2b second");
    chk("b2b second x", bus.o_x, 255'd57);
    chk("b2b second y", bus.o_y, 255'd57);
    @(negedge clk);

    // Reset while in S_MUL_Y aborts without a finished pulse.
    launch(255'd8, 255'd8);
    repeat (lmm + 20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort x", bus.o_x, 255'd0);
    chk("abort y", bus.o_y, 255'd0);
    chk("abort z", bus.o_z, 255'd0);
    chk("abort busy", 255'(bus.o_busy), 255'd0);
    chk("abort fin", 255'(bus.o_finished), 255'd0);
    @(negedge clk);
    rst_n = 1'b1;
    f0 = n_fin;
    repeat (700) @(negedge clk);
    chk("abort no pulse", 255'(n_fin - f0), 255'd0);
    chk("abort idle", 255'(bus.o_busy), 255'd0);
    lift("after_reset", 255'd5, 255'd7, 255'd95, 255'd133);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/projective_lift.md
PROJECTIVE_LIFT -- requirements
Module: projective_lift

Interface
REQ-001 The module SHALL have parameter P_Q, default 2^255-19, meaning the field prime q.
REQ-002 The module SHALL have parameter P_R_MOD, default 255'd19, meaning R mod q with R = 2^255.
REQ-003 The module SHALL have parameter P_R2_MOD, default 255'd361, meaning R^2 mod q.
REQ-004 i_clk  input  1  single clock, rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  one-cycle request that samples i_x and i_y.
REQ-007 i_x, i_y  input  255 each  affine coordinates, any value in 0..2^255-1.
REQ-008 o_x, o_y, o_z  output  255 each  projective Montgomery-domain coordinates (xR, yR, R) mod q.
REQ-009 o_busy  output  1  high from the cycle after an accepted i_start until o_finished.
REQ-010 o_finished  output  1  one-cycle pulse marking o_x/o_y/o_z valid.

Function
REQ-011 The block SHALL instantiate one team Montgomery multiplier (i_start, i_a, i_b, o_montgomery = a*b*R^-1 mod q, o_finished) and SHALL wait on its o_finished, never on a fixed latency.
REQ-012 The FSM SHALL have exactly four states: S_IDLE, S_MUL_X, S_MUL_Y, S_DONE.
REQ-013 In S_IDLE with i_start=1, the block SHALL latch i_x and i_y, each reduced by one conditional subtraction (v >= q ? v-q : v).
REQ-014 In the same S_IDLE cycle, the block SHALL pulse the multiplier start with a = reduced i_x and b = P_R2_MOD, then go to S_MUL_X.
REQ-015 In S_MUL_X, on multiplier o_finished, the block SHALL register the product into x_r, start a multiply of (y_r, P_R2_MOD) in the same cycle, and go to S_MUL_Y.
REQ-016 In S_MUL_Y, on multiplier o_finished, the block SHALL register the product into y_r and go to S_DONE.
REQ-017 In S_DONE, the block SHALL load z_r = P_R_MOD, assert o_finished on the next cycle for exactly one cycle, and return to S_IDLE.
REQ-018 Output latency SHALL be 2*L_mm + 2 cycles from i_start to o_finished, where L_mm is the multiplier start-to-finished latency.
REQ-019 i_start outside S_IDLE SHALL be ignored with no effect on registers or state.
REQ-020 o_x/o_y/o_z SHALL hold their last values between operations; intermediate products SHALL be visible on o_x/o_y while o_busy=1, and consumers sample only on o_finished.
REQ-021 i_start in the same cycle o_finished is high SHALL be accepted, since the FSM is then in S_IDLE.
REQ-022 All arithmetic SHALL be 255-bit unsigned; the conditional subtract SHALL use a 256-bit compare so that no wrap occurs.
REQ-023 Every output value SHALL be in the range 0..q-1.

Reset
REQ-024 On i_rst_n low, asynchronously: state = S_IDLE; x_r, y_r, z_r = 0; o_busy = 0; o_finished = 0; the multiplier start is deasserted.
REQ-025 Reset asserted mid-operation SHALL abort the operation, produce no o_finished pulse, and require a new i_start after release.
REQ-026 The multiplier instance SHALL be reset by the same i_rst_n (active-low), adapted to its reset port polarity.

Verification
REQ-027 i_x=1, i_y=1 -> o_x=19, o_y=19, o_z=19, one o_finished pulse.
REQ-028 i_x=2, i_y=3 -> o_x=38, o_y=57, o_z=19; the latency equals 2*L_mm+2 measured against the multiplier.
REQ-029 i_x=q, i_y=q+1 -> input reduction yields o_x=0, o_y=19, o_z=19.
REQ-030 i_x=q-1, i_y=0 -> o_x=q-19, o_y=0; the test then round-trips through the projective-to-affine reduction block and recovers x=q-1 normalized to even form (q-1 is even, so unchanged) and y=0.
REQ-031 A second i_start during S_MUL_X with different data -> it is ignored; the results match the first request, and only one o_finished pulse occurs.
REQ-032 i_rst_n pulsed low during S_MUL_Y -> all outputs 0 and no o_finished; a subsequent i_start with x=5, y=7 -> o_x=95, o_y=133, o_z=19.
